// File: rtl/eth_fifo_pkg.sv
// eth_fifo_pkg: shared types and helpers for the Ethernet RX frame FIFO.
//   rx_fifo_state_t : write-side state (ACCEPT a frame, or DROP its tail)
//   DROP_CNT_W      : width of the saturating dropped-frame counter
//   ptr_diff()      : modular pointer difference; callers truncate the
//                     result to their own pointer width
package eth_fifo_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } rx_fifo_state_t;

  localparam int DROP_CNT_W = 16;
  localparam int PTR_CALC_W = 32;

  // Pointers wrap naturally, so a plain subtraction truncated back to the
  // pointer width gives the distance even across a wrap.
  function automatic logic [PTR_CALC_W-1:0] ptr_diff(
    input logic [PTR_CALC_W-1:0] a,
    input logic [PTR_CALC_W-1:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/eth_fifo_ram.sv
// eth_fifo_ram: simple dual-port memory, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : mem[raddr], combinational
// Contents are not reset.
module eth_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: frame-aware receive FIFO between MAC RX and host/DMA.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   wr_en/wr_data  : one word per cycle from the MAC, never backpressured
//   wr_last        : marks the final word of a frame
//   wr_err         : frame bad; only looked at on the last word
//   wr_overflow    : registered one-cycle pulse after a write hit a full FIFO
//   rd_valid/rd_ready/rd_data/rd_last : first-word-fall-through read port
//   level          : committed unread words (registered)
//   frame_cnt      : committed frames not yet fully read
//   almost_full    : written-but-unread words >= AFULL_THRESH (registered)
//   drop_cnt       : saturating count of discarded frames
//
// Read handshake: rd_valid depends only on registered pointers and never on
// rd_ready; a word transfers on every rising edge where rd_valid && rd_ready,
// and rd_data/rd_last are held stable while rd_valid is high and no transfer
// occurs.
//
// Frames are written speculatively at wr_ptr; commit_ptr only advances on a
// good last word, so the reader (bounded by commit_ptr) never sees a partial
// or bad frame. A bad or overflowing frame is discarded by rewinding wr_ptr.
module eth_rx_frame_fifo
  import eth_fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 2048,
  parameter int AFULL_THRESH = DEPTH - 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_last,
  input  logic                    wr_err,
  output logic                    wr_overflow,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_last,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  frame_cnt,
  output logic                    almost_full,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = ADDR_W + 1;

  rx_fifo_state_t        state, state_nxt;
  logic [PW-1:0]         wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]         commit_ptr, commit_ptr_nxt;
  logic [PW-1:0]         rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]         used, used_nxt, level_nxt, frame_cnt_nxt;
  logic [DROP_CNT_W-1:0] drop_cnt_nxt;
  logic                  full, ram_we, commit_fire, drop_fire, ovf_nxt;
  logic                  rd_fire;
  logic [DATA_W:0]       ram_rdata;

  // Occupancy from registered pointers only: a read in this cycle does not
  // make room for a write in this cycle.
  assign used = PW'(ptr_diff(PTR_CALC_W'(wr_ptr), PTR_CALC_W'(rd_ptr)));
  assign full = (used == PW'(DEPTH));

  assign rd_valid = (rd_ptr != commit_ptr);
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_data  = ram_rdata[DATA_W-1:0];
  assign rd_last  = ram_rdata[DATA_W];

  // Write-side FSM: next state and pointer updates
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    ram_we         = 1'b0;
    commit_fire    = 1'b0;
    drop_fire      = 1'b0;
    ovf_nxt        = 1'b0;
    case (state)
      ACCEPT: begin
        if (wr_en) begin
          if (full) begin
            ovf_nxt    = 1'b1;
            drop_fire  = 1'b1;
            wr_ptr_nxt = commit_ptr;
            // The rest of this frame is swallowed unless this was its end.
            if (!wr_last) begin
              state_nxt = DROP;
            end
          end else if (wr_last && wr_err) begin
            drop_fire  = 1'b1;
            wr_ptr_nxt = commit_ptr;
          end else begin
            ram_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (wr_last) begin
              commit_fire    = 1'b1;
              commit_ptr_nxt = wr_ptr + 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (wr_en && wr_last) begin
          state_nxt = ACCEPT;
        end
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // Read pointer and statistics
  always_comb begin
    rd_ptr_nxt    = rd_ptr + PW'(rd_fire);
    frame_cnt_nxt = frame_cnt;
    case ({commit_fire, rd_fire && rd_last})
      2'b10:   frame_cnt_nxt = frame_cnt + 1'b1;
      2'b01:   frame_cnt_nxt = frame_cnt - 1'b1;
      default: frame_cnt_nxt = frame_cnt;
    endcase
    drop_cnt_nxt = drop_cnt;
    if (drop_fire && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_nxt = drop_cnt + 1'b1;
    end
    level_nxt = PW'(ptr_diff(PTR_CALC_W'(commit_ptr_nxt), PTR_CALC_W'(rd_ptr_nxt)));
    used_nxt  = PW'(ptr_diff(PTR_CALC_W'(wr_ptr_nxt), PTR_CALC_W'(rd_ptr_nxt)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCEPT;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      commit_ptr  <= commit_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      frame_cnt   <= frame_cnt_nxt;
      drop_cnt    <= drop_cnt_nxt;
      level       <= level_nxt;
      almost_full <= (int'(used_nxt) >= AFULL_THRESH);
      wr_overflow <= ovf_nxt;
    end
  end

  eth_fifo_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({wr_last, wr_data}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
Parametrised, frame-aware receive FIFO between the MAC RX datapath and the host/DMA side. The write side is not backpressured, matching the MAC. Frames become visible to the reader only after their last byte is written with good status. Frames flagged bad by the MAC, or that overflow the buffer, are rewound and discarded whole. The read side is first-word-fall-through with a valid/ready handshake, plus occupancy, frame-count and drop statistics.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 2048, number of entries; power of two, >= 4
AFULL_THRESH, DEPTH-16, almost_full asserts when the total written-but-unread count is >= this value (1..DEPTH)
ADDR_W (localparam), $clog2(DEPTH), memory address width; pointers are ADDR_W+1 bits

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe from the MAC, one word per cycle
wr_data  in  DATA_W  write word
wr_last  in  1  qualifies the final word of a frame
wr_err  in  1  frame bad (FCS/alignment); sampled only when wr_en && wr_last
wr_overflow  out  1  one-cycle pulse: a write was attempted while full
rd_valid  out  1  a committed word is available
rd_ready  in  1  reader accepts the word
rd_data  out  DATA_W  head word (fall-through)
rd_last  out  1  head word is the last word of a frame
level  out  ADDR_W+1  committed, unread words: commit_ptr - rd_ptr
frame_cnt  out  ADDR_W+1  complete frames committed and not fully read
almost_full  out  1  (wr_ptr - rd_ptr) >= AFULL_THRESH
drop_cnt  out  16  saturating count of discarded frames

Behaviour:
- Storage: DEPTH x (DATA_W+1); the stored word is {last, data}.
- Pointers: wr_ptr (speculative), commit_ptr, rd_ptr. Each is ADDR_W+1 bits, wraps naturally; the MSB distinguishes full from empty.
- full = (wr_ptr - rd_ptr) == DEPTH. It is computed from registered pointers only, so a read in the same cycle does not free space for a write in that cycle.
- Reset: all pointers 0, state ACCEPT. Outputs: wr_overflow, rd_valid, level, frame_cnt, almost_full and drop_cnt are 0. rd_data/rd_last are don't-care while rd_valid=0. Memory contents are not cleared.
- A reset mid-frame or mid-read discards everything. The first write after reset starts a new frame.
- FSM, two states:
  - ACCEPT, wr_en && !full: write mem[wr_ptr], wr_ptr+1.
    - If wr_last && !wr_err: commit_ptr <= wr_ptr+1, frame_cnt+1.
    - If wr_last && wr_err: wr_ptr <= commit_ptr (rewind), drop_cnt+1. The errored word is not stored.
  - ACCEPT, wr_en && full: pulse wr_overflow, wr_ptr <= commit_ptr, drop_cnt+1.
    - If !wr_last, go to DROP. If wr_last, stay in ACCEPT.
  - DROP: ignore all writes (no overflow pulses). On wr_en && wr_last, return to ACCEPT next cycle. wr_err is ignored.
- Frames longer than the free space, including frames longer than DEPTH, take the overflow path.
- Read (FWFT): rd_valid = (rd_ptr != commit_ptr); {rd_last, rd_data} = mem[rd_ptr] (asynchronous read).
  - Transfer on rd_valid && rd_ready: rd_ptr+1. If rd_last, frame_cnt-1.
  - Commit and last-word read in the same cycle: frame_cnt unchanged.
- Latency: the word written with good wr_last is visible (rd_valid=1) in the cycle after that write. Uncommitted words are never readable.
- level and almost_full are registered and reflect the pointers after the previous edge.
- drop_cnt saturates at 16'hFFFF.
- Writing while the reader drains a different frame is fully concurrent.

Decomposition:
- Package eth_fifo_pkg:
  - enum rx_fifo_state_t {ACCEPT, DROP}
  - DROP_CNT_W = 16
  - pointer-difference helper function
- Sub-module eth_fifo_ram: simple dual-port memory, synchronous write, asynchronous read, parameters WIDTH/DEPTH. The parent instantiates it with WIDTH = DATA_W+1.

Test Plan:
(All with DEPTH=16, AFULL_THRESH=12.)
- Good frame: write 5 bytes 0x10..0x14 with last on 0x14, err=0, rd_ready=1.
  -> rd_valid rises the cycle after 0x14; reads 0x10..0x14 with rd_last only on 0x14; frame_cnt 1->0; level 5->0.
- Bad frame: write 4 bytes with last+err=1, then a good 3-byte frame.
  -> drop_cnt=1; only the 3-byte frame is read; rd_valid stays 0 during the bad frame.
- Overflow: rd_ready=0, commit one 10-byte frame, then stream a 9-byte frame.
  -> wr_overflow pulses once on its 7th byte; drop_cnt=1; level=10.
  -> almost_full=1 after the 12th stored word, and 0 again after the rewind.
  -> A following 3-byte frame commits (level=13).
- Simultaneous read and write: drain a 16-byte frame while writing a new one.
  -> Writes stall into overflow only when (wr_ptr-rd_ptr)==16 at the edge.
  -> A pointer wrap past 16 reads back correct data.
- Commit and last-read in the same cycle.
  -> frame_cnt is unchanged that cycle.
  -> Reset asserted mid-frame: rd_valid, level and frame_cnt go to 0 immediately; the next frame is written and read from pointer 0.
